// File: rtl/noc_traffic_node_pkg.sv
// ============================================================================
// noc_traffic_node_pkg : shared NoC flit layout, index/sequence widths and
//                        traffic-node state types.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_traffic_node_pkg;

   localparam int c_noc_data_width     = 32;
   localparam int c_noc_id_x_width     = 4;
   localparam int c_noc_id_y_width     = 4;
   localparam int c_noc_head_h         = 31;
   localparam int c_noc_head_e         = 28;
   localparam int c_noc_tail_h         = 31;
   localparam int c_noc_tail_e         = 28;
   localparam int c_noc_point_h        = 16;
   localparam int c_noc_source_point   = 8;
   localparam int c_noc_dest_point     = 0;
   localparam int c_noc_flit_idx_width = 8;
   localparam int c_noc_seq_width      = 16;

   localparam logic [c_noc_head_h-c_noc_head_e:0] c_noc_head_code = 4'hA;
   localparam logic [c_noc_tail_h-c_noc_tail_e:0] c_noc_tail_code = 4'h5;

   typedef logic [c_noc_data_width-1:0] flit_t;

   typedef enum logic [2:0] {
      TX_IDLE, TX_GAP, TX_HEAD, TX_BODY, TX_TAIL, TX_DONE
   } tx_state_t;

   typedef enum logic [0:0] {
      RX_IDLE, RX_BODY
   } rx_state_t;

   function automatic flit_t make_head(input logic [c_noc_id_x_width-1:0] sx,
                                       input logic [c_noc_id_y_width-1:0] sy,
                                       input logic [c_noc_id_x_width-1:0] dx,
                                       input logic [c_noc_id_y_width-1:0] dy);
      flit_t f;
      f = '0;
      f[c_noc_head_h:c_noc_head_e]                  = c_noc_head_code;
      f[c_noc_point_h-1:c_noc_source_point]         = {sx, sy};
      f[c_noc_source_point-1:c_noc_dest_point]      = {dx, dy};
      return f;
   endfunction

   function automatic flit_t make_body(input logic [c_noc_seq_width-1:0]      seq,
                                       input logic [c_noc_flit_idx_width-1:0] k);
      flit_t f;
      f = '0;
      f[c_noc_seq_width+c_noc_flit_idx_width-1:0] = {seq, k};
      return f;
   endfunction

   function automatic flit_t make_tail();
      flit_t f;
      f = '0;
      f[c_noc_tail_h:c_noc_tail_e] = c_noc_tail_code;
      return f;
   endfunction

endpackage

`default_nettype wire

// File: rtl/noc_traffic_rx_vc.sv
// ============================================================================
// noc_traffic_rx_vc : per-VC packet framing tracker; payload sequence check
//                     when NOC_TRAFFIC_CHECK_EN is defined.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_traffic_rx_vc
   import noc_traffic_node_pkg::*;
#(
   parameter int DATA_FLITS = 1
) (
   input  logic                        noc_clk,
   input  logic                        noc_rst_n,
   input  logic                        flit_valid,
   input  logic [c_noc_data_width-1:0] flit,
   input  logic                        is_header,
   input  logic                        is_tail,
   output logic                        pkt_done,
   output logic                        proto_err
);

   localparam logic [c_noc_flit_idx_width-1:0] c_data_flits = c_noc_flit_idx_width'(DATA_FLITS);
   localparam int c_src_width = c_noc_point_h - c_noc_source_point;

   rx_state_t                        r_state;
   logic [c_noc_flit_idx_width-1:0]  r_cnt;
   logic [c_src_width-1:0]           r_src;
   logic                             w_body_bad;
   logic                             w_unused_bits;

   assign w_unused_bits = ^{flit, r_src};

`ifdef NOC_TRAFFIC_CHECK_EN
   localparam int c_pay_width = c_noc_seq_width + c_noc_flit_idx_width;

   logic [c_noc_seq_width-1:0] r_exp_seq [2**c_src_width];
   logic [c_pay_width-1:0]     w_got;

   assign w_got      = flit[c_pay_width-1:0];
   assign w_body_bad = (w_got != {r_exp_seq[r_src], r_cnt});

   // A mismatch adopts the received sequence so one lost packet is one error.
   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         for (int i = 0; i < 2**c_src_width; i++) r_exp_seq[i] <= '0;
      end else if (flit_valid && !is_header && r_state == RX_BODY) begin
         if (is_tail)
            r_exp_seq[r_src] <= r_exp_seq[r_src] + c_noc_seq_width'(1);
         else if (w_body_bad)
            r_exp_seq[r_src] <= w_got[c_pay_width-1 -: c_noc_seq_width];
      end
   end
`else
   assign w_body_bad = 1'b0;
`endif

   always_comb begin
      pkt_done  = 1'b0;
      proto_err = 1'b0;
      if (flit_valid) begin
         if (is_header && is_tail)     proto_err = 1'b1;
         else if (is_header)           proto_err = (r_state == RX_BODY);
         else if (r_state == RX_IDLE)  proto_err = 1'b1;
         else if (is_tail) begin
            if (r_cnt == c_data_flits) pkt_done  = 1'b1;
            else                       proto_err = 1'b1;
         end else                      proto_err = (r_cnt == c_data_flits) || w_body_bad;
      end
   end

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         r_state <= RX_IDLE;
         r_cnt   <= '0;
         r_src   <= '0;
      end else if (flit_valid) begin
         if (is_header && is_tail) begin
            r_state <= RX_IDLE;
         end else if (is_header) begin
            r_state <= RX_BODY;
            r_cnt   <= '0;
            r_src   <= flit[c_noc_point_h-1:c_noc_source_point];
         end else if (is_tail) begin
            r_state <= RX_IDLE;
         end else if (r_state == RX_BODY && r_cnt != c_data_flits) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/noc_traffic_node.sv
// ============================================================================
// noc_traffic_node : NoC packet generator plus per-VC receive checker.
//                    Optional payload check: define NOC_TRAFFIC_CHECK_EN.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_traffic_node
   import noc_traffic_node_pkg::*;
#(
   parameter logic [c_noc_id_x_width-1:0] X_ID      = '0,
   parameter logic [c_noc_id_y_width-1:0] Y_ID      = '0,
   parameter logic [c_noc_id_x_width-1:0] DEST_X_ID = '0,
   parameter logic [c_noc_id_y_width-1:0] DEST_Y_ID = '0,
   parameter int DATA_FLITS = 1,
   parameter int PKT_COUNT  = 51,
   parameter int GAP_CYCLES = 0,
   parameter int VC_NUM     = 1
) (
   input  logic                        noc_clk,
   input  logic                        noc_rst_n,
   input  logic [VC_NUM-1:0]           receive_valid,
   output logic [VC_NUM-1:0]           receive_ready,
   input  logic [c_noc_data_width-1:0] receive_flit,
   input  logic                        receive_is_header,
   input  logic                        receive_is_tail,
   output logic                        sender_valid,
   input  logic                        sender_ready,
   output logic [c_noc_data_width-1:0] sender_flit,
   output logic                        sender_is_header,
   output logic                        sender_is_tail,
   output logic                        tx_done,
   output logic [15:0]                 rx_pkt_count,
   output logic                        rx_err
);

   // ---------------------------------------------------------------- transmit
   tx_state_t                        r_state;
   logic [c_noc_seq_width-1:0]       r_sent;
   logic [c_noc_flit_idx_width-1:0]  r_k;
   logic [7:0]                       r_gap;
   logic [c_noc_seq_width:0]         w_next_sent;
   logic                             w_more;
   logic                             w_launch;
   logic [c_noc_data_width-1:0]      w_head;

   assign w_head      = make_head(X_ID, Y_ID, DEST_X_ID, DEST_Y_ID);
   assign w_next_sent = {1'b0, r_sent} + {{c_noc_seq_width{1'b0}}, (r_state == TX_TAIL)};
   assign w_more      = w_next_sent < (c_noc_seq_width+1)'(PKT_COUNT);
   // Launch decisions are folded into the tail/gap edge so packets run back-to-back.
   assign w_launch    = (r_state == TX_IDLE)
                     || (r_state == TX_TAIL && sender_ready && GAP_CYCLES == 0)
                     || (r_state == TX_GAP  && r_gap == 8'd0);

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         r_state          <= TX_IDLE;
         r_sent           <= '0;
         r_k              <= '0;
         r_gap            <= '0;
         sender_valid     <= 1'b0;
         sender_flit      <= '0;
         sender_is_header <= 1'b0;
         sender_is_tail   <= 1'b0;
         tx_done          <= 1'b0;
      end else begin
         case (r_state)
            TX_HEAD: if (sender_ready) begin
               r_state          <= TX_BODY;
               r_k              <= '0;
               sender_flit      <= make_body(r_sent, '0);
               sender_is_header <= 1'b0;
            end
            TX_BODY: if (sender_ready) begin
               if (r_k == c_noc_flit_idx_width'(DATA_FLITS - 1)) begin
                  r_state        <= TX_TAIL;
                  sender_flit    <= make_tail();
                  sender_is_tail <= 1'b1;
               end else begin
                  r_k         <= r_k + 1'b1;
                  sender_flit <= make_body(r_sent, r_k + 1'b1);
               end
            end
            TX_TAIL: if (sender_ready) begin
               r_sent         <= w_next_sent[c_noc_seq_width-1:0];
               r_state        <= TX_GAP;
               r_gap          <= 8'(GAP_CYCLES - 1);
               sender_valid   <= 1'b0;
               sender_is_tail <= 1'b0;
            end
            TX_GAP:  r_gap <= r_gap - 1'b1;
            default: ;
         endcase
         if (w_launch) begin
            if (w_more) begin
               r_state          <= TX_HEAD;
               sender_valid     <= 1'b1;
               sender_flit      <= w_head;
               sender_is_header <= 1'b1;
            end else begin
               r_state      <= TX_DONE;
               sender_valid <= 1'b0;
               sender_flit  <= '0;
               tx_done      <= 1'b1;
            end
         end
      end
   end

   // ----------------------------------------------------------------- receive
   logic [VC_NUM-1:0]  w_fire;
   logic [VC_NUM-1:0]  w_vc_done;
   logic [VC_NUM-1:0]  w_vc_err;
   logic [3:0]         w_done_cnt;
   logic [16:0]        w_cnt_sum;
   logic               w_multi;

   assign w_fire    = receive_valid & receive_ready;
   assign w_multi   = $countones(receive_valid) > 1;
   assign w_cnt_sum = {1'b0, rx_pkt_count} + {13'b0, w_done_cnt};

   always_comb begin
      w_done_cnt = '0;
      for (int i = 0; i < VC_NUM; i++) w_done_cnt = w_done_cnt + {3'b0, w_vc_done[i]};
   end

   for (genvar g = 0; g < VC_NUM; g++) begin : g_rx_vc
      noc_traffic_rx_vc #(
         .DATA_FLITS (DATA_FLITS)
      ) u_rx_vc (
         .noc_clk    (noc_clk),
         .noc_rst_n  (noc_rst_n),
         .flit_valid (w_fire[g]),
         .flit       (receive_flit),
         .is_header  (receive_is_header),
         .is_tail    (receive_is_tail),
         .pkt_done   (w_vc_done[g]),
         .proto_err  (w_vc_err[g])
      );
   end

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         receive_ready <= '0;
         rx_err        <= 1'b0;
         rx_pkt_count  <= '0;
      end else begin
         receive_ready <= '1;
         rx_err        <= rx_err | w_multi | (|w_vc_err);
         rx_pkt_count  <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_noc_traffic_node.sv
// ============================================================================
// tb_noc_traffic_node : directed checks of TX sequencing, stall, reset,
//                       loopback and RX framing on three node instances.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_traffic_node;

   logic noc_clk = 1'b0;
   always #5 noc_clk = ~noc_clk;

   int errors = 0;
   int checks = 0;

   // u_tx: DATA_FLITS=3, PKT_COUNT=2, GAP=0
   logic        tx_rst_n, tx_ready;
   logic        tx_valid, tx_h, tx_t, tx_done, tx_err;
   logic [31:0] tx_flit;
   logic [15:0] tx_cnt;
   logic [0:0]  tx_rready;

   // u_rx: DATA_FLITS=2, PKT_COUNT=0, VC_NUM=2, receive side driven directly
   logic        rx_rst_n;
   logic [1:0]  rx_valid, rx_rready;
   logic [31:0] rx_flit, rx_sflit;
   logic        rx_h, rx_t, rx_svalid, rx_sh, rx_st, rx_done, rx_err;
   logic [15:0] rx_cnt;

   // u_lb: PKT_COUNT=4, GAP=2, sender looped into VC0
   logic        lb_rst_n;
   logic        lb_valid, lb_h, lb_t, lb_done, lb_err;
   logic [31:0] lb_flit;
   logic [15:0] lb_cnt;
   logic [0:0]  lb_rready;

   noc_traffic_node #(
      .X_ID(4'd1), .Y_ID(4'd2), .DEST_X_ID(4'd3), .DEST_Y_ID(4'd4),
      .DATA_FLITS(3), .PKT_COUNT(2), .GAP_CYCLES(0), .VC_NUM(1)
   ) u_tx (
      .noc_clk(noc_clk), .noc_rst_n(tx_rst_n),
      .receive_valid(1'b0), .receive_ready(tx_rready), .receive_flit(32'h0),
      .receive_is_header(1'b0), .receive_is_tail(1'b0),
      .sender_valid(tx_valid), .sender_ready(tx_ready), .sender_flit(tx_flit),
      .sender_is_header(tx_h), .sender_is_tail(tx_t),
      .tx_done(tx_done), .rx_pkt_count(tx_cnt), .rx_err(tx_err)
   );

   noc_traffic_node #(
      .DATA_FLITS(2), .PKT_COUNT(0), .GAP_CYCLES(0), .VC_NUM(2)
   ) u_rx (
      .noc_clk(noc_clk), .noc_rst_n(rx_rst_n),
      .receive_valid(rx_valid), .receive_ready(rx_rready), .receive_flit(rx_flit),
      .receive_is_header(rx_h), .receive_is_tail(rx_t),
      .sender_valid(rx_svalid), .sender_ready(1'b1), .sender_flit(rx_sflit),
      .sender_is_header(rx_sh), .sender_is_tail(rx_st),
      .tx_done(rx_done), .rx_pkt_count(rx_cnt), .rx_err(rx_err)
   );

   noc_traffic_node #(
      .X_ID(4'd5), .DATA_FLITS(1), .PKT_COUNT(4), .GAP_CYCLES(2), .VC_NUM(1)
   ) u_lb (
      .noc_clk(noc_clk), .noc_rst_n(lb_rst_n),
      .receive_valid(lb_valid), .receive_ready(lb_rready), .receive_flit(lb_flit),
      .receive_is_header(lb_h), .receive_is_tail(lb_t),
      .sender_valid(lb_valid), .sender_ready(lb_rready[0]), .sender_flit(lb_flit),
      .sender_is_header(lb_h), .sender_is_tail(lb_t),
      .tx_done(lb_done), .rx_pkt_count(lb_cnt), .rx_err(lb_err)
   );

   localparam logic [31:0] HEAD_TX = 32'hA000_1234;
   localparam logic [31:0] HEAD_11 = 32'hA000_1100;
   localparam logic [31:0] HEAD_22 = 32'hA000_2200;
   localparam logic [31:0] TAIL    = 32'h5000_0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tx_step(input string tag, input logic [31:0] f, input logic h, input logic t);
      @(posedge noc_clk); #1;
      chk({tag, ".valid"}, {31'b0, tx_valid}, 32'd1);
      chk({tag, ".flit"},  tx_flit, f);
      chk({tag, ".hdr"},   {31'b0, tx_h}, {31'b0, h});
      chk({tag, ".tail"},  {31'b0, tx_t}, {31'b0, t});
   endtask

   task automatic rx_send(input logic [1:0] mask, input logic [31:0] f, input logic h, input logic t);
      rx_valid = mask; rx_flit = f; rx_h = h; rx_t = t;
      @(posedge noc_clk); #1;
      rx_valid = 2'b00; rx_h = 1'b0; rx_t = 1'b0;
   endtask

   logic [31:0] exp_f [10];
   logic [9:0]  exp_h, exp_t;

   initial begin
      tx_rst_n = 1'b0; rx_rst_n = 1'b0; lb_rst_n = 1'b0;
      tx_ready = 1'b1;
      rx_valid = 2'b00; rx_flit = 32'h0; rx_h = 1'b0; rx_t = 1'b0;
      exp_f = '{HEAD_TX, 32'h0, 32'h1, 32'h2, TAIL, HEAD_TX, 32'h100, 32'h101, 32'h102, TAIL};
      exp_h = 10'b00001_00001;
      exp_t = 10'b10000_10000;

      repeat (2) @(posedge noc_clk);
      #1;
      chk("rst.valid", {31'b0, tx_valid}, 32'd0);
      chk("rst.flit",  tx_flit, 32'd0);
      chk("rst.hdr",   {31'b0, tx_h}, 32'd0);
      chk("rst.tail",  {31'b0, tx_t}, 32'd0);
      chk("rst.done",  {31'b0, tx_done}, 32'd0);
      chk("rst.err",   {31'b0, tx_err}, 32'd0);
      chk("rst.cnt",   {16'b0, tx_cnt}, 32'd0);
      chk("rst.rready", {30'b0, rx_rready}, 32'd0);

      tx_rst_n = 1'b1; rx_rst_n = 1'b1; lb_rst_n = 1'b1;
      @(posedge noc_clk); #1;
      chk("rready.rx", {30'b0, rx_rready}, 32'h3);
      chk("rready.tx", {31'b0, tx_rready}, 32'h1);
      chk("zero_pkt.done",  {31'b0, rx_done}, 32'd1);
      chk("zero_pkt.valid", {31'b0, rx_svalid}, 32'd0);

      // Two back-to-back packets, first flit already presented
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("b2b[%0d].valid", i), {31'b0, tx_valid}, 32'd1);
         chk($sformatf("b2b[%0d].flit", i), tx_flit, exp_f[i]);
         chk($sformatf("b2b[%0d].hdr", i), {31'b0, tx_h}, {31'b0, exp_h[i]});
         chk($sformatf("b2b[%0d].tail", i), {31'b0, tx_t}, {31'b0, exp_t[i]});
         @(posedge noc_clk); #1;
      end
      chk("b2b.done",  {31'b0, tx_done}, 32'd1);
      chk("b2b.valid", {31'b0, tx_valid}, 32'd0);
      @(posedge noc_clk); #1;
      chk("done.hold", {31'b0, tx_valid}, 32'd0);

      // Async reset clears tx_done without a clock edge
      tx_rst_n = 1'b0; #1;
      chk("async.done",  {31'b0, tx_done}, 32'd0);
      chk("async.valid", {31'b0, tx_valid}, 32'd0);
      tx_rst_n = 1'b1;

      tx_step("stall.h",  HEAD_TX, 1'b1, 1'b0);
      tx_step("stall.d0", 32'h0, 1'b0, 1'b0);
      tx_step("stall.d1", 32'h1, 1'b0, 1'b0);
      tx_ready = 1'b0;
      repeat (5) tx_step("stall.hold", 32'h1, 1'b0, 1'b0);
      tx_ready = 1'b1;
      tx_step("stall.d2",  32'h2, 1'b0, 1'b0);
      tx_step("stall.t",   TAIL, 1'b0, 1'b1);
      tx_step("p1.h",      HEAD_TX, 1'b1, 1'b0);
      tx_step("p1.d0",     32'h100, 1'b0, 1'b0);
      tx_step("p1.d1",     32'h101, 1'b0, 1'b0);
      tx_step("p1.d2",     32'h102, 1'b0, 1'b0);
      tx_step("p1.t",      TAIL, 1'b0, 1'b1);

      // Reset during TAIL of the second packet
      tx_rst_n = 1'b0; #1;
      chk("tailrst.valid", {31'b0, tx_valid}, 32'd0);
      chk("tailrst.flit",  tx_flit, 32'd0);
      chk("tailrst.hdr",   {31'b0, tx_h}, 32'd0);
      chk("tailrst.tail",  {31'b0, tx_t}, 32'd0);
      chk("tailrst.done",  {31'b0, tx_done}, 32'd0);
      tx_rst_n = 1'b1;
      tx_step("restart.h",  HEAD_TX, 1'b1, 1'b0);
      tx_step("restart.d0", 32'h0, 1'b0, 1'b0);

      // Interleaved packets on VC0 / VC1
      rx_send(2'b01, HEAD_11, 1'b1, 1'b0);
      rx_send(2'b10, HEAD_22, 1'b1, 1'b0);
      rx_send(2'b01, 32'h0, 1'b0, 1'b0);
      rx_send(2'b10, 32'h0, 1'b0, 1'b0);
      rx_send(2'b01, 32'h1, 1'b0, 1'b0);
      rx_send(2'b10, 32'h1, 1'b0, 1'b0);
      rx_send(2'b01, TAIL, 1'b0, 1'b1);
      chk("ilv.cnt1", {16'b0, rx_cnt}, 32'd1);
      rx_send(2'b10, TAIL, 1'b0, 1'b1);
      chk("ilv.cnt2", {16'b0, rx_cnt}, 32'd2);
      chk("ilv.err",  {31'b0, rx_err}, 32'd0);

      // Short packet, then a well-formed one on the same VC
      rx_send(2'b01, HEAD_11, 1'b1, 1'b0);
      rx_send(2'b01, 32'h100, 1'b0, 1'b0);
      rx_send(2'b01, TAIL, 1'b0, 1'b1);
      chk("short.err", {31'b0, rx_err}, 32'd1);
      chk("short.cnt", {16'b0, rx_cnt}, 32'd2);
      rx_send(2'b01, HEAD_11, 1'b1, 1'b0);
      rx_send(2'b01, 32'h200, 1'b0, 1'b0);
      rx_send(2'b01, 32'h201, 1'b0, 1'b0);
      rx_send(2'b01, TAIL, 1'b0, 1'b1);
      chk("resync.cnt", {16'b0, rx_cnt}, 32'd3);
      chk("resync.err", {31'b0, rx_err}, 32'd1);

      // Multiple valid bits in one cycle
      rx_rst_n = 1'b0; #1;
      chk("rxrst.cnt",    {16'b0, rx_cnt}, 32'd0);
      chk("rxrst.err",    {31'b0, rx_err}, 32'd0);
      chk("rxrst.rready", {30'b0, rx_rready}, 32'd0);
      rx_rst_n = 1'b1;
      @(posedge noc_clk); #1;
      rx_send(2'b11, HEAD_11, 1'b1, 1'b0);
      chk("multi.err", {31'b0, rx_err}, 32'd1);

      // Header+tail flit, then a good packet from IDLE
      rx_rst_n = 1'b0; #1;
      rx_rst_n = 1'b1;
      @(posedge noc_clk); #1;
      rx_send(2'b01, HEAD_11, 1'b1, 1'b1);
      chk("ht.err", {31'b0, rx_err}, 32'd1);
      chk("ht.cnt", {16'b0, rx_cnt}, 32'd0);
      rx_send(2'b01, HEAD_11, 1'b1, 1'b0);
      rx_send(2'b01, 32'h0, 1'b0, 1'b0);
      rx_send(2'b01, 32'h1, 1'b0, 1'b0);
      rx_send(2'b01, TAIL, 1'b0, 1'b1);
      chk("ht.after_cnt", {16'b0, rx_cnt}, 32'd1);

      // Loopback, bounded wait
      for (int i = 0; i < 300 && !lb_done; i++) @(posedge noc_clk);
      #1;
      chk("lb.done",  {31'b0, lb_done}, 32'd1);
      chk("lb.cnt",   {16'b0, lb_cnt}, 32'd4);
      chk("lb.err",   {31'b0, lb_err}, 32'd0);
      chk("lb.valid", {31'b0, lb_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
